aes_host_link: RTL and testbench

Byte-stream host interface for the AES cores. Accepts a command header, optional key bytes and one 16-byte block over a valid/ready byte input, drives the encrypt/decrypt core with a start pulse, waits for the core's done level, then returns the 16-byte result over a valid/ready byte output. It replaces hard-wired plaintext/key constants with a loadable path and sits between a UART/byte bridge and the AES_Encrypt/AES_Decrypt instances.

---
 rtl/aes_host_link_if.sv | 20 ++
 rtl/aes_host_link.sv | 212 +++++++++++++++++++++
 tb/tb_aes_host_link.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_host_link_if.sv
// aes_host_link_if: valid/ready byte-stream bundle between the byte bridge (master)
// and aes_host_link (slave): one input stream to the block, one output stream back.
interface aes_host_link_if;
   logic [7:0] in_byte;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_byte, in_valid, out_ready,
      input  in_ready, out_byte, out_valid
   );

   modport slave (
      input  in_byte, in_valid, out_ready,
      output in_ready, out_byte, out_valid
   );
endinterface

// File: rtl/aes_host_link.sv
// aes_host_link: header/key/block byte loader that runs an AES core and streams back the result.
// Optional macro AES_HOST_TIMEOUT_EN bounds the wait for core_done to TIMEOUT cycles.
module aes_host_link
`ifdef AES_HOST_TIMEOUT_EN
   #(parameter int unsigned TIMEOUT = 64)
`endif
   (
   input  logic           clk,
   input  logic           reset,
   aes_host_link_if.slave host,
   output logic [127:0]   core_data,
   output logic [255:0]   core_key,
   output logic [1:0]     core_mode,
   output logic           core_dec,
   output logic           core_go,
   input  logic           core_done,
   input  logic [127:0]   core_result,
   output logic           busy,
   output logic           err
   );

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY,
      S_DATA,
      S_RUN,
      S_SEND
   } state_e;

   state_e       state_q, state_d;
   logic [1:0]   cmd_mode_q, cmd_mode_d;
   logic         cmd_dec_q, cmd_dec_d;
   logic [255:0] key_q, key_d;
   logic         key_valid_q, key_valid_d;
   logic [1:0]   key_mode_q, key_mode_d;
   logic [127:0] data_q, data_d;
   logic [127:0] result_q, result_d;
   logic [5:0]   cnt_q, cnt_d;
   logic         first_q, first_d;
   logic         err_q, err_d;
   logic         rdy_q, rdy_d;
   logic [5:0]   key_last;
   logic         in_hs;
   logic         out_hs;
`ifdef AES_HOST_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   assign in_hs  = host.in_valid && rdy_q;
   assign out_hs = (state_q == S_SEND) && host.out_ready;

   always_comb begin
      unique case (cmd_mode_q)
         2'b00:   key_last = 6'd15;
         2'b01:   key_last = 6'd23;
         default: key_last = 6'd31;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cmd_mode_q  <= 2'b00;
         cmd_dec_q   <= 1'b0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         key_mode_q  <= 2'b00;
         data_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         err_q       <= 1'b0;
         rdy_q       <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_mode_q  <= cmd_mode_d;
         cmd_dec_q   <= cmd_dec_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_mode_q  <= key_mode_d;
         data_q      <= data_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         err_q       <= err_d;
         rdy_q       <= rdy_d;
`ifdef AES_HOST_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_mode_d  = cmd_mode_q;
      cmd_dec_d   = cmd_dec_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      key_mode_d  = key_mode_q;
      data_d      = data_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      err_d       = err_q;
`ifdef AES_HOST_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_hs) begin
               cmd_mode_d = host.in_byte[1:0];
               cmd_dec_d  = host.in_byte[3];
               cnt_d      = '0;
               if (host.in_byte[1:0] == 2'b11) begin
                  err_d   = 1'b0;
                  state_d = S_DATA;
               end else if (host.in_byte[2]) begin
                  // Zeroing up front leaves the unused low key bits clear for 128/192.
                  err_d       = 1'b0;
                  key_d       = '0;
                  key_valid_d = 1'b0;
                  state_d     = S_KEY;
               end else if (key_valid_q && (key_mode_q == host.in_byte[1:0])) begin
                  err_d   = 1'b0;
                  state_d = S_DATA;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_KEY: begin
            if (in_hs) begin
               for (int unsigned i = 0; i < 32; i++) begin
                  if (cnt_q == 6'(i)) key_d[8*(31-i) +: 8] = host.in_byte;
               end
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == key_last) begin
                  key_valid_d = 1'b1;
                  key_mode_d  = cmd_mode_q;
                  cnt_d       = '0;
                  state_d     = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (in_hs) begin
               data_d = {data_q[119:0], host.in_byte};
               cnt_d  = cnt_q + 6'd1;
               if (cnt_q == 6'd15) begin
                  cnt_d = '0;
                  if (cmd_mode_q == 2'b11) begin
                     result_d = {data_q[119:0], host.in_byte};
                     state_d  = S_SEND;
                  end else begin
                     first_d = 1'b1;
`ifdef AES_HOST_TIMEOUT_EN
                     tmo_d   = '0;
`endif
                     state_d = S_RUN;
                  end
               end
            end
         end
         S_RUN: begin
            // core_done is only trusted from the cycle after the start pulse.
            first_d = 1'b0;
            if (!first_q && core_done) begin
               result_d = core_result;
               state_d  = S_SEND;
            end
`ifdef AES_HOST_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         S_SEND: begin
            if (out_hs) begin
               result_d = {result_q[119:0], 8'h00};
               cnt_d    = cnt_q + 6'd1;
               if (cnt_q == 6'd15) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      rdy_d = (state_d == S_IDLE) || (state_d == S_KEY) || (state_d == S_DATA);
   end

   always_comb begin
      host.in_ready  = rdy_q;
      host.out_valid = (state_q == S_SEND);
      host.out_byte  = (state_q == S_SEND) ? result_q[127:120] : 8'h00;
      core_go        = (state_q == S_RUN) && first_q;
      busy           = (state_q != S_IDLE);
      err            = err_q;
      core_data      = data_q;
      core_key       = key_q;
      core_mode      = cmd_mode_q;
      core_dec       = cmd_dec_q;
   end

endmodule

// File: tb/tb_aes_host_link.sv
// tb_aes_host_link: directed bench with a behavioural core model and an output-byte scoreboard.
module tb_aes_host_link;
  logic clk;
  logic rst_n;
  logic [127:0] core_data;
  logic [255:0] core_key;
  logic [1:0]   core_mode;
  logic         core_dec;
  logic         core_go;
  logic         core_done;
  logic [127:0] core_result;
  logic         busy;
  logic         err;

  aes_host_link_if hif();

`ifdef AES_HOST_TIMEOUT_EN
  aes_host_link #(.TIMEOUT(64)) dut (
`else
  aes_host_link dut (
`endif
    .clk(clk), .reset(rst_n), .host(hif),
    .core_data(core_data), .core_key(core_key), .core_mode(core_mode),
    .core_dec(core_dec), .core_go(core_go), .core_done(core_done),
    .core_result(core_result), .busy(busy), .err(err)
  );

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BYPASS = 128'hdeadbeef0123456789abcdeffedcba98;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  int           go_cnt = 0;
  logic [127:0] cap_data;
  logic [255:0] cap_key;
  logic [1:0]   cap_mode;
  logic         cap_dec;
  logic [127:0] core_rsp;
  logic         core_hang;
  logic         rand_ready;
  logic         stalled = 1'b0;
  logic [7:0]   held_byte;
  logic [7:0]   exp_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  // Behavioural core: answers each start pulse with core_rsp three cycles later.
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_go) begin
        go_cnt++;
        cap_data = core_data;
        cap_key  = core_key;
        cap_mode = core_mode;
        cap_dec  = core_dec;
        if (!core_hang) begin
          repeat (3) @(posedge clk);
          #1;
          core_result = core_rsp;
          core_done   = 1'b1;
          @(posedge clk);
          #1;
          chk("out_valid_after_done", hif.out_valid === 1'b1);
          core_done = 1'b0;
        end
      end
    end
  end

  initial begin
    hif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      hif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (hif.out_valid) begin
      if (stalled) chk("out_hold", hif.out_byte === held_byte);
      if (hif.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", hif.out_valid === 1'b0);
        else begin
          exp_b = exp_q.pop_front();
          chk("out_byte", hif.out_byte === exp_b);
        end
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_byte = hif.out_byte;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned w = 0;
    hif.in_byte  = b;
    hif.in_valid = 1'b1;
    @(negedge clk);
    while (!hif.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!hif.in_ready) chk("in_ready_wait", hif.in_ready === 1'b1);
    @(posedge clk);
    #1;
    hif.in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [255:0] k, input int n);
    for (int i = 0; i < n; i++) send_byte(k[255-8*i -: 8]);
  endtask

  task automatic send_blk(input logic [127:0] b);
    for (int i = 0; i < 16; i++) send_byte(b[127-8*i -: 8]);
  endtask

  task automatic push_blk(input logic [127:0] b);
    for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
  endtask

  // Returns one cycle after the final output handshake.
  task automatic wait_drain(input string tag);
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk({tag, "_drained"}, exp_q.size() === 0);
    @(posedge clk);
    #1;
    chk({tag, "_busy_end"}, busy === 1'b0);
    chk({tag, "_in_ready_end"}, hif.in_ready === 1'b1);
  endtask

  initial begin
    int g;
    rst_n        = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_byte  = 8'h00;
    core_rsp     = '0;
    core_hang    = 1'b0;
    rand_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", hif.in_ready === 1'b0);
    chk("rst_ctrl", {hif.out_valid, hif.out_byte, core_go, busy, err, core_mode, core_dec} === 15'h0);
    chk("rst_core_data", core_data === 128'h0);
    chk("rst_core_key", core_key === 256'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", hif.in_ready === 1'b1);
    chk("rel_busy", busy === 1'b0);

    g = go_cnt;
    push_blk(CT128);
    core_rsp = CT128;
    send_byte(8'h04);
    send_key(K128, 16);
    send_blk(PT);
    chk("t1_go_m1", core_go === 1'b1);
    chk("t1_in_ready_run", hif.in_ready === 1'b0);
    @(posedge clk);
    #1;
    chk("t1_go_single", core_go === 1'b0);
    wait_drain("t1");
    chk("t1_go_count", (go_cnt - g) === 1);
    chk("t1_mode", cap_mode === 2'b00);
    chk("t1_key", cap_key === K128);
    chk("t1_data", cap_data === PT);

    push_blk(CT192);
    core_rsp = CT192;
    send_byte(8'h05);
    send_key(K192, 24);
    send_blk(PT);
    wait_drain("t2a");
    chk("t2a_mode", cap_mode === 2'b01);
    chk("t2a_dec", cap_dec === 1'b0);
    push_blk(PT);
    core_rsp = PT;
    send_byte(8'h09);
    send_blk(CT192);
    wait_drain("t2b");
    chk("t2b_key", cap_key === K192);
    chk("t2b_key_low", cap_key[63:0] === 64'h0);
    chk("t2b_dec", cap_dec === 1'b1);
    chk("t2b_data", cap_data === CT192);

    send_byte(8'h02);
    chk("t3_err_set", err === 1'b1);
    chk("t3_idle", busy === 1'b0);
    chk("t3_in_ready", hif.in_ready === 1'b1);
    push_blk(CT256);
    core_rsp = CT256;
    send_byte(8'h06);
    chk("t3_err_clr", err === 1'b0);
    send_key(K256, 32);
    send_blk(PT);
    wait_drain("t3");
    chk("t3_key", cap_key === K256);
    chk("t3_mode", cap_mode === 2'b10);

    g = go_cnt;
    push_blk(BYPASS);
    rand_ready = 1'b1;
    send_byte(8'h03);
    send_blk(BYPASS);
    chk("t4_valid_m1", hif.out_valid === 1'b1);
    chk("t4_no_go", core_go === 1'b0);
    wait_drain("t4");
    rand_ready = 1'b0;
    chk("t4_go_count", (go_cnt - g) === 0);

    send_byte(8'h0A);
    for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", {hif.in_ready, hif.out_valid, hif.out_byte, core_go, busy, err, core_mode, core_dec} === 16'h0);
    chk("t5_rst_data", core_data === 128'h0);
    chk("t5_rst_key", core_key === 256'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h02);
    chk("t5_key_invalid_err", err === 1'b1);
    chk("t5_idle", busy === 1'b0);

`ifdef AES_HOST_TIMEOUT_EN
    core_hang = 1'b1;
    send_byte(8'h06);
    send_key(K256, 32);
    send_blk(PT);
    chk("t6_go", core_go === 1'b1);
    for (int k = 1; k < 64; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_err_before", err === 1'b0);
    chk("t6_busy_before", busy === 1'b1);
    @(posedge clk);
    #1;
    chk("t6_err_at_64", err === 1'b1);
    chk("t6_busy_after", busy === 1'b0);
    chk("t6_no_out", hif.out_valid === 1'b0);
    core_hang = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size() === 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
